hpdcache_flush_sweep: RTL and testbench
=======================================

HPDCACHE_FLUSH_SWEEP -- requirements
Module: hpdcache_flush_sweep

Interface
REQ-001 SHALL have parameter HPDcacheCfg, default '0, meaning the cache configuration (sets, ways, setWidth, tagWidth, nlineWidth).
REQ-002 SHALL have type parameters hpdcache_set_t, hpdcache_tag_t, hpdcache_nline_t and hpdcache_way_vector_t, each defaulting to logic, meaning the widths derived from HPDcacheCfg.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk_i  in  1  clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 sweep_start_i  in  1  request a full-cache writeback sweep.
REQ-007 sweep_inval_i  in  1  invalidate lines after writeback; sampled with an accepted start.
REQ-008 sweep_busy_o  out  1  sweep in progress.
REQ-009 sweep_done_o  out  1  one-cycle pulse when the sweep is complete.
REQ-010 dir_rd_o  out  1  directory read request for one set (all ways).
REQ-011 dir_rd_gnt_i  in  1  directory read accepted this cycle.
REQ-012 dir_rd_set_o  out  setWidth  set being read.
REQ-013 dir_rd_dirty_i  in  ways  per-way valid&dirty mask; valid exactly 1 cycle after grant.
REQ-014 dir_rd_tags_i  in  ways*tagWidth  per-way tags; valid with dir_rd_dirty_i.
REQ-015 dir_clean_o  out  1  clear the dirty bit (or valid, when inval) of one way.
REQ-016 dir_clean_set_o  out  setWidth  set of the cleared line.
REQ-017 dir_clean_way_o  out  ways  way of the cleared line, one-hot.
REQ-018 dir_clean_inval_o  out  1  clear valid as well as dirty.
REQ-019 flush_alloc_o  out  1  writeback request to the flush controller.
REQ-020 flush_alloc_ready_i  in  1  flush controller accepts the request.
REQ-021 flush_alloc_nline_o  out  nlineWidth  {tag, set} of the line.
REQ-022 flush_alloc_way_o  out  ways  one-hot way of the line.
REQ-023 flush_alloc_inval_o  out  1  latched sweep_inval_i.
REQ-024 flush_empty_i  in  1  no writebacks outstanding in the flush controller.

Function
REQ-025 FSM states SHALL be IDLE, READ, WAIT, SCAN, DRAIN.
REQ-026 IDLE: sweep_start_i SHALL clear the set counter to 0, latch sweep_inval_i, and go to READ; sweep_start_i while busy SHALL be ignored.
REQ-027 READ: dir_rd_o=1 with dir_rd_set_o=counter; on dir_rd_gnt_i go to WAIT, otherwise hold.
REQ-028 WAIT (one cycle): latch dir_rd_dirty_i into a dirty mask and the tags into a register; go to SCAN.
REQ-029 SCAN, mask nonzero: flush_alloc_o=1 for the lowest-index set bit, with nline={tag[way], counter}.
REQ-030 SCAN handshake (flush_alloc_o & flush_alloc_ready_i): clear that mask bit; pulse dir_clean_o for that set/way in the same cycle.
REQ-031 SCAN outputs SHALL stay stable while flush_alloc_o=1 and flush_alloc_ready_i=0.
REQ-032 SCAN, mask zero (including a set read with no dirty ways): if counter = sets-1 go to DRAIN; else increment counter and go to READ.
REQ-033 The mask SHALL be updated so a set with k dirty ways takes exactly k handshakes and no extra idle cycle before the next-set decision.
REQ-034 DRAIN: on flush_empty_i go to IDLE and pulse sweep_done_o for 1 cycle.
REQ-035 The set counter SHALL be setWidth wide; the last-set compare SHALL prevent wrap past sets-1.
REQ-036 sweep_busy_o SHALL be 1 in every state except IDLE.
REQ-037 dir_clean_o and flush_alloc_o SHALL never assert outside SCAN.

Reset
REQ-038 rst_i SHALL force IDLE, counter 0, mask 0, and every output 0, including during a sweep.
REQ-039 A sweep in progress at reset SHALL be abandoned, and no done pulse SHALL be generated.

Structure
REQ-040 The FSM state enum SHALL be local; the nline/set/tag/way types SHALL come from hpdcache_pkg-derived parameters.
REQ-041 Lowest-set-bit way selection SHALL use a fixed-priority sub-module hpdcache_prio_1hot_encoder.

Verification
REQ-042 4 sets x 2 ways, no dirty lines; start -> 4 reads at sets 0..3, no alloc, done 1 cycle after flush_empty_i.
REQ-043 Set 2 dirty mask 2'b11, tags 0x5/0x9, ready=1 -> allocs nline {0x5,2} way 01 then {0x9,2} way 10 on consecutive cycles, each with dir_clean_o.
REQ-044 Ready held 0 for 3 cycles -> flush_alloc_o and its payload stable for all 3 cycles, exactly one clean pulse.
REQ-045 dir_rd_gnt_i delayed 5 cycles -> dir_rd_o held with unchanged set; sampling occurs 1 cycle after grant.
REQ-046 Start with sweep_inval_i=1, then a second start mid-sweep -> flush_alloc_inval_o=1 throughout, second start ignored; a single done pulse only after flush_empty_i.
REQ-047 rst_i asserted in SCAN -> next cycle all outputs 0 and FSM in IDLE; no done pulse.

Source files
------------

// File: rtl/hpdcache_flush_sweep_pkg.sv
// rtl/hpdcache_flush_sweep_pkg.sv - cache configuration type and helpers for the flush sweep
package hpdcache_flush_sweep_pkg;

    typedef struct packed {
        int unsigned sets;
        int unsigned ways;
        int unsigned setWidth;
        int unsigned tagWidth;
        int unsigned nlineWidth;
    } hpdcache_cfg_t;

    // An unset configuration falls back to the full range of the set index type
    function automatic int unsigned hpdcache_sweep_sets(hpdcache_cfg_t cfg, int unsigned set_width);
        return (cfg.sets != 0) ? cfg.sets : (32'd1 << set_width);
    endfunction

endpackage

// File: rtl/hpdcache_prio_1hot_encoder.sv
// rtl/hpdcache_prio_1hot_encoder.sv - fixed-priority one-hot select of the lowest set bit
module hpdcache_prio_1hot_encoder #(
    parameter int N = 4
) (
    input  logic [N-1:0] val_i,
    output logic [N-1:0] val_o
);

    logic found;

    always_comb begin
        val_o = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (val_i[i] && !found) begin
                val_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hpdcache_flush_sweep.sv
// rtl/hpdcache_flush_sweep.sv - walks every cache set and hands dirty lines to the flush controller
module hpdcache_flush_sweep
    import hpdcache_flush_sweep_pkg::*;
#(
    parameter hpdcache_cfg_t HPDcacheCfg = '0,
    parameter type hpdcache_set_t        = logic,
    parameter type hpdcache_tag_t        = logic,
    parameter type hpdcache_nline_t      = logic,
    parameter type hpdcache_way_vector_t = logic,
    localparam int Ways = $bits(hpdcache_way_vector_t)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     sweep_start_i,
    input  logic                     sweep_inval_i,
    output logic                     sweep_busy_o,
    output logic                     sweep_done_o,
    output logic                     dir_rd_o,
    input  logic                     dir_rd_gnt_i,
    output hpdcache_set_t            dir_rd_set_o,
    input  hpdcache_way_vector_t     dir_rd_dirty_i,
    input  hpdcache_tag_t [Ways-1:0] dir_rd_tags_i,
    output logic                     dir_clean_o,
    output hpdcache_set_t            dir_clean_set_o,
    output hpdcache_way_vector_t     dir_clean_way_o,
    output logic                     dir_clean_inval_o,
    output logic                     flush_alloc_o,
    input  logic                     flush_alloc_ready_i,
    output hpdcache_nline_t          flush_alloc_nline_o,
    output hpdcache_way_vector_t     flush_alloc_way_o,
    output logic                     flush_alloc_inval_o,
    input  logic                     flush_empty_i
);

    localparam int unsigned   Sets    = hpdcache_sweep_sets(HPDcacheCfg, $bits(hpdcache_set_t));
    localparam hpdcache_set_t LastSet = hpdcache_set_t'(Sets - 1);

    typedef enum logic [2:0] {IDLE, READ, WAIT, SCAN, DRAIN} state_e;

    state_e                   state_q;
    hpdcache_set_t            cnt_q;
    logic [Ways-1:0]          mask_q;
    logic [Ways-1:0]          sel_way;
    hpdcache_tag_t [Ways-1:0] tags_q;
    hpdcache_tag_t            sel_tag;
    logic                     inval_q;
    logic                     done_q;
    logic                     scan_hs;
    logic                     set_finished;

    hpdcache_prio_1hot_encoder #(
        .N(Ways)
    ) i_way_sel (
        .val_i(mask_q),
        .val_o(sel_way)
    );

    always_comb begin
        sel_tag = '0;
        for (int w = 0; w < Ways; w++) begin
            if (sel_way[w]) sel_tag = tags_q[w];
        end
    end

    // The next-set decision is taken on the last handshake so k dirty ways cost exactly k cycles
    assign scan_hs      = (state_q == SCAN) && (|mask_q) && flush_alloc_ready_i;
    assign set_finished = (state_q == SCAN) &&
                          ((mask_q == '0) || (scan_hs && ((mask_q & ~sel_way) == '0)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
            tags_q  <= '0;
            inval_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sweep_start_i) begin
                        cnt_q   <= '0;
                        inval_q <= sweep_inval_i;
                        state_q <= READ;
                    end
                end
                READ: begin
                    if (dir_rd_gnt_i) state_q <= WAIT;
                end
                WAIT: begin
                    mask_q  <= dir_rd_dirty_i;
                    tags_q  <= dir_rd_tags_i;
                    state_q <= SCAN;
                end
                SCAN: begin
                    if (scan_hs) mask_q <= mask_q & ~sel_way;
                    if (set_finished) begin
                        if (cnt_q == LastSet) begin
                            state_q <= DRAIN;
                        end else begin
                            cnt_q   <= cnt_q + hpdcache_set_t'(1);
                            state_q <= READ;
                        end
                    end
                end
                DRAIN: begin
                    if (flush_empty_i) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sweep_busy_o        = (state_q != IDLE);
    assign sweep_done_o        = done_q;
    assign dir_rd_o            = (state_q == READ);
    assign dir_rd_set_o        = cnt_q;
    assign flush_alloc_o       = (state_q == SCAN) && (|mask_q);
    assign flush_alloc_nline_o = hpdcache_nline_t'({sel_tag, cnt_q});
    assign flush_alloc_way_o   = hpdcache_way_vector_t'(sel_way);
    assign flush_alloc_inval_o = inval_q;
    assign dir_clean_o         = scan_hs;
    assign dir_clean_set_o     = cnt_q;
    assign dir_clean_way_o     = hpdcache_way_vector_t'(sel_way);
    assign dir_clean_inval_o   = inval_q;

endmodule

// File: tb/tb_hpdcache_flush_sweep.sv
// tb/tb_hpdcache_flush_sweep.sv - directed bench for the 4-set x 2-way flush sweep
module tb_hpdcache_flush_sweep;
    import hpdcache_flush_sweep_pkg::*;

    typedef logic [1:0] set_t;
    typedef logic [3:0] tag_t;
    typedef logic [5:0] nline_t;
    typedef logic [1:0] way_t;

    localparam hpdcache_cfg_t Cfg = '{sets: 4, ways: 2, setWidth: 2, tagWidth: 4, nlineWidth: 6};

    logic       clk = 1'b0;
    logic       rst_i, sweep_start_i, sweep_inval_i, dir_rd_gnt_i, flush_alloc_ready_i, flush_empty_i;
    way_t       dir_rd_dirty_i;
    tag_t [1:0] dir_rd_tags_i;
    logic       sweep_busy_o, sweep_done_o, dir_rd_o, dir_clean_o, dir_clean_inval_o;
    logic       flush_alloc_o, flush_alloc_inval_o;
    set_t       dir_rd_set_o, dir_clean_set_o;
    way_t       dir_clean_way_o, flush_alloc_way_o;
    nline_t     flush_alloc_nline_o;

    way_t       mdl_dirty [4];
    tag_t [1:0] mdl_tags  [4];
    int         gnt_delay;
    int         tests_run = 0;
    int         tests_failed = 0;

    int         cyc;
    int         rd_log[$];
    int         rd_cyc[$];
    nline_t     al_nline[$];
    way_t       al_way[$];
    logic       al_inv[$];
    int         al_cyc[$];
    int         clean_cnt, clean_bad, done_cnt;

    hpdcache_flush_sweep #(
        .HPDcacheCfg(Cfg),
        .hpdcache_set_t(set_t),
        .hpdcache_tag_t(tag_t),
        .hpdcache_nline_t(nline_t),
        .hpdcache_way_vector_t(way_t)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .sweep_start_i(sweep_start_i),
        .sweep_inval_i(sweep_inval_i),
        .sweep_busy_o(sweep_busy_o),
        .sweep_done_o(sweep_done_o),
        .dir_rd_o(dir_rd_o),
        .dir_rd_gnt_i(dir_rd_gnt_i),
        .dir_rd_set_o(dir_rd_set_o),
        .dir_rd_dirty_i(dir_rd_dirty_i),
        .dir_rd_tags_i(dir_rd_tags_i),
        .dir_clean_o(dir_clean_o),
        .dir_clean_set_o(dir_clean_set_o),
        .dir_clean_way_o(dir_clean_way_o),
        .dir_clean_inval_o(dir_clean_inval_o),
        .flush_alloc_o(flush_alloc_o),
        .flush_alloc_ready_i(flush_alloc_ready_i),
        .flush_alloc_nline_o(flush_alloc_nline_o),
        .flush_alloc_way_o(flush_alloc_way_o),
        .flush_alloc_inval_o(flush_alloc_inval_o),
        .flush_empty_i(flush_empty_i)
    );

    always #5 clk = ~clk;

    // Directory: grant after gnt_delay READ cycles, real data only in the cycle after grant
    initial begin : dir_model
        logic hs_q;
        set_t hs_set;
        int   rd_wait;
        hs_q = 1'b0; hs_set = '0; rd_wait = 0;
        dir_rd_gnt_i = 1'b0; dir_rd_dirty_i = '1; dir_rd_tags_i = '1;
        forever begin
            @(posedge clk); #1;
            if (hs_q) begin
                dir_rd_dirty_i = mdl_dirty[hs_set];
                dir_rd_tags_i  = mdl_tags[hs_set];
            end else begin
                dir_rd_dirty_i = '1;
                dir_rd_tags_i  = '1;
            end
            if (dir_rd_o) begin
                dir_rd_gnt_i = (rd_wait >= gnt_delay);
                rd_wait++;
            end else begin
                dir_rd_gnt_i = 1'b0;
                rd_wait = 0;
            end
            hs_q   = dir_rd_o && dir_rd_gnt_i;
            hs_set = dir_rd_set_o;
        end
    end

    initial begin : monitor
        cyc = 0;
        forever begin
            @(negedge clk); #4;
            cyc++;
            if (!rst_i) begin
                if (dir_rd_o && dir_rd_gnt_i) begin
                    rd_log.push_back(int'(dir_rd_set_o));
                    rd_cyc.push_back(cyc);
                end
                if (flush_alloc_o && flush_alloc_ready_i) begin
                    al_nline.push_back(flush_alloc_nline_o);
                    al_way.push_back(flush_alloc_way_o);
                    al_inv.push_back(flush_alloc_inval_o);
                    al_cyc.push_back(cyc);
                end
                if (dir_clean_o) begin
                    clean_cnt++;
                    if (!(flush_alloc_o && flush_alloc_ready_i) || dir_clean_way_o !== flush_alloc_way_o ||
                        dir_clean_set_o !== flush_alloc_nline_o[1:0] || dir_clean_inval_o !== flush_alloc_inval_o)
                        clean_bad++;
                end
                if ((dir_clean_o || flush_alloc_o) && !sweep_busy_o) clean_bad++;
                if (sweep_done_o) done_cnt++;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic reset_model();
        for (int s = 0; s < 4; s++) begin
            mdl_dirty[s] = '0;
            mdl_tags[s]  = '0;
        end
        gnt_delay = 0;
        rd_log.delete(); rd_cyc.delete();
        al_nline.delete(); al_way.delete(); al_inv.delete(); al_cyc.delete();
        clean_cnt = 0; clean_bad = 0; done_cnt = 0;
    endtask

    task automatic start_sweep(input logic inval);
        sweep_inval_i = inval;
        sweep_start_i = 1'b1;
        step();
        sweep_start_i = 1'b0;
        sweep_inval_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            if (done_cnt > 0) ok = 1'b1;
        end
        step();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step(); step();
        tests_run++;
        if (sweep_busy_o !== 1'b0 || sweep_done_o !== 1'b0 || dir_rd_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: busy=%b done=%b rd=%b required 0 0 0", sweep_busy_o, sweep_done_o, dir_rd_o);
        end
        tests_run++;
        if (flush_alloc_o !== 1'b0 || dir_clean_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_req: alloc=%b clean=%b required 0 0", flush_alloc_o, dir_clean_o);
        end
        tests_run++;
        if ({dir_rd_set_o, flush_alloc_nline_o, flush_alloc_way_o, dir_clean_way_o, dir_clean_set_o,
             flush_alloc_inval_o, dir_clean_inval_o} !== '0) begin
            tests_failed++;
            $display("FAIL reset_payload: set=%h nline=%h way=%b cway=%b inv=%b required all 0",
                     dir_rd_set_o, flush_alloc_nline_o, flush_alloc_way_o, dir_clean_way_o, flush_alloc_inval_o);
        end
        rst_i = 1'b0;
        step();
        tests_run++;
        if (sweep_busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_busy: got %b required 0", sweep_busy_o);
        end
    endtask

    task automatic test_no_dirty();
        reset_model();
        flush_empty_i = 1'b0;
        start_sweep(1'b0);
        for (int i = 0; i < 100 && rd_log.size() < 4; i++) step();
        for (int i = 0; i < 5; i++) step();
        tests_run++;
        if (rd_log.size() != 4 || rd_log[0] != 0 || rd_log[1] != 1 || rd_log[2] != 2 || rd_log[3] != 3) begin
            tests_failed++;
            $display("FAIL clean_read_sets: got %0d reads first=%0d last=%0d required 4 reads 0..3",
                     rd_log.size(), rd_log[0], rd_log[rd_log.size()-1]);
        end
        tests_run++;
        if (al_nline.size() != 0 || clean_cnt != 0) begin
            tests_failed++;
            $display("FAIL clean_no_alloc: got allocs=%0d cleans=%0d required 0 0", al_nline.size(), clean_cnt);
        end
        tests_run++;
        if (sweep_busy_o !== 1'b1 || done_cnt != 0) begin
            tests_failed++;
            $display("FAIL clean_drain_hold: busy=%b dones=%0d required busy 1 dones 0", sweep_busy_o, done_cnt);
        end
        flush_empty_i = 1'b1;
        step();
        tests_run++;
        if (sweep_done_o !== 1'b1 || sweep_busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL clean_done_pulse: done=%b busy=%b required 1 0", sweep_done_o, sweep_busy_o);
        end
        step();
        tests_run++;
        if (sweep_done_o !== 1'b0 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL clean_done_width: done=%b dones=%0d required 0 1", sweep_done_o, done_cnt);
        end
    endtask

    task automatic test_dirty_pair();
        logic ok;
        reset_model();
        mdl_dirty[2] = 2'b11;
        mdl_tags[2]  = {4'h9, 4'h5};
        flush_alloc_ready_i = 1'b1;
        flush_empty_i = 1'b1;
        start_sweep(1'b0);
        wait_done(200, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL pair_timeout: done seen=%b required 1", ok);
        end
        tests_run++;
        if (al_nline.size() != 2 || al_nline[0] !== 6'h16 || al_way[0] !== 2'b01 ||
            al_nline[1] !== 6'h26 || al_way[1] !== 2'b10) begin
            tests_failed++;
            $display("FAIL pair_allocs: n=%0d nline0=%h way0=%b nline1=%h way1=%b required 2 16 01 26 10",
                     al_nline.size(), al_nline[0], al_way[0], al_nline[1], al_way[1]);
        end
        tests_run++;
        if (al_cyc.size() != 2 || al_cyc[1] - al_cyc[0] != 1) begin
            tests_failed++;
            $display("FAIL pair_consecutive: gap=%0d required 1", al_cyc[1] - al_cyc[0]);
        end
        tests_run++;
        if (rd_cyc.size() != 4 || rd_cyc[3] - al_cyc[1] != 1) begin
            tests_failed++;
            $display("FAIL pair_next_set_gap: gap=%0d required 1", rd_cyc[3] - al_cyc[1]);
        end
        tests_run++;
        if (clean_cnt != 2 || clean_bad != 0 || al_inv[0] !== 1'b0 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL pair_clean: cleans=%0d bad=%0d inv=%b dones=%0d required 2 0 0 1",
                     clean_cnt, clean_bad, al_inv[0], done_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic ok;
        reset_model();
        mdl_dirty[1] = 2'b10;
        mdl_tags[1]  = {4'hA, 4'h0};
        flush_alloc_ready_i = 1'b0;
        start_sweep(1'b0);
        for (int i = 0; i < 50 && !flush_alloc_o; i++) step();
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (flush_alloc_o !== 1'b1 || flush_alloc_nline_o !== 6'h29 || flush_alloc_way_o !== 2'b10 ||
                dir_clean_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_stable_%0d: alloc=%b nline=%h way=%b clean=%b required 1 29 10 0",
                         i, flush_alloc_o, flush_alloc_nline_o, flush_alloc_way_o, dir_clean_o);
            end
            step();
        end
        flush_alloc_ready_i = 1'b1;
        wait_done(200, ok);
        tests_run++;
        if (!ok || clean_cnt != 1 || clean_bad != 0 || al_nline.size() != 1 || al_nline[0] !== 6'h29) begin
            tests_failed++;
            $display("FAIL bp_single_clean: done=%b cleans=%0d bad=%0d allocs=%0d required 1 1 0 1",
                     ok, clean_cnt, clean_bad, al_nline.size());
        end
    endtask

    task automatic test_gnt_delay();
        logic ok;
        reset_model();
        gnt_delay = 5;
        mdl_dirty[0] = 2'b01;
        mdl_tags[0]  = {4'h0, 4'h3};
        start_sweep(1'b0);
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (dir_rd_o !== 1'b1 || dir_rd_set_o !== 2'd0 || rd_log.size() != 0) begin
                tests_failed++;
                $display("FAIL gnt_hold_%0d: rd=%b set=%0d reads=%0d required 1 0 0",
                         i, dir_rd_o, dir_rd_set_o, rd_log.size());
            end
            step();
        end
        wait_done(300, ok);
        tests_run++;
        if (!ok || al_nline.size() != 1 || al_nline[0] !== 6'h0C || al_way[0] !== 2'b01) begin
            tests_failed++;
            $display("FAIL gnt_sample: done=%b allocs=%0d nline=%h way=%b required 1 1 0c 01",
                     ok, al_nline.size(), al_nline[0], al_way[0]);
        end
        tests_run++;
        if (rd_log.size() != 4 || rd_log[3] != 3 || al_cyc[0] - rd_cyc[0] != 2) begin
            tests_failed++;
            $display("FAIL gnt_latency: reads=%0d alloc_after_grant=%0d required 4 2",
                     rd_log.size(), al_cyc[0] - rd_cyc[0]);
        end
        gnt_delay = 0;
    endtask

    task automatic test_inval_restart();
        reset_model();
        mdl_dirty[1] = 2'b01;
        mdl_tags[1]  = {4'h0, 4'h7};
        mdl_dirty[3] = 2'b10;
        mdl_tags[3]  = {4'hC, 4'h0};
        flush_empty_i = 1'b0;
        start_sweep(1'b1);
        for (int i = 0; i < 100 && al_nline.size() < 1; i++) step();
        start_sweep(1'b0);
        for (int i = 0; i < 100 && rd_log.size() < 4; i++) step();
        for (int i = 0; i < 6; i++) step();
        tests_run++;
        if (rd_log.size() != 4 || rd_log[0] != 0 || rd_log[3] != 3 || done_cnt != 0 || sweep_busy_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL inv_restart_ignored: reads=%0d dones=%0d busy=%b required 4 0 1",
                     rd_log.size(), done_cnt, sweep_busy_o);
        end
        tests_run++;
        if (al_nline.size() != 2 || al_nline[0] !== 6'h1D || al_way[0] !== 2'b01 ||
            al_nline[1] !== 6'h33 || al_way[1] !== 2'b10) begin
            tests_failed++;
            $display("FAIL inv_allocs: n=%0d nline0=%h nline1=%h required 2 1d 33",
                     al_nline.size(), al_nline[0], al_nline[1]);
        end
        tests_run++;
        if (al_inv[0] !== 1'b1 || al_inv[1] !== 1'b1 || flush_alloc_inval_o !== 1'b1 || clean_bad != 0) begin
            tests_failed++;
            $display("FAIL inv_flag: inv0=%b inv1=%b now=%b bad=%0d required 1 1 1 0",
                     al_inv[0], al_inv[1], flush_alloc_inval_o, clean_bad);
        end
        flush_empty_i = 1'b1;
        step();
        tests_run++;
        if (sweep_done_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL inv_done: got %b required 1", sweep_done_o);
        end
        step(); step();
        tests_run++;
        if (done_cnt != 1) begin
            tests_failed++;
            $display("FAIL inv_single_done: got %0d required 1", done_cnt);
        end
    endtask

    task automatic test_reset_in_scan();
        reset_model();
        mdl_dirty[0] = 2'b11;
        mdl_tags[0]  = {4'h4, 4'h2};
        flush_alloc_ready_i = 1'b0;
        start_sweep(1'b1);
        for (int i = 0; i < 50 && !flush_alloc_o; i++) step();
        tests_run++;
        if (flush_alloc_o !== 1'b1 || flush_alloc_nline_o !== 6'h08) begin
            tests_failed++;
            $display("FAIL rscan_reach: alloc=%b nline=%h required 1 08", flush_alloc_o, flush_alloc_nline_o);
        end
        rst_i = 1'b1;
        step();
        tests_run++;
        if ({sweep_busy_o, sweep_done_o, dir_rd_o, flush_alloc_o, dir_clean_o, flush_alloc_inval_o,
             dir_clean_inval_o} !== 7'b0) begin
            tests_failed++;
            $display("FAIL rscan_ctrl: busy=%b done=%b rd=%b alloc=%b clean=%b inv=%b required all 0",
                     sweep_busy_o, sweep_done_o, dir_rd_o, flush_alloc_o, dir_clean_o, flush_alloc_inval_o);
        end
        tests_run++;
        if ({flush_alloc_nline_o, flush_alloc_way_o, dir_clean_way_o, dir_rd_set_o, dir_clean_set_o} !== '0) begin
            tests_failed++;
            $display("FAIL rscan_payload: nline=%h way=%b cway=%b set=%0d required all 0",
                     flush_alloc_nline_o, flush_alloc_way_o, dir_clean_way_o, dir_rd_set_o);
        end
        rst_i = 1'b0;
        flush_alloc_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) step();
        tests_run++;
        if (done_cnt != 0 || sweep_busy_o !== 1'b0 || al_nline.size() != 0 || clean_cnt != 0) begin
            tests_failed++;
            $display("FAIL rscan_abandon: dones=%0d busy=%b allocs=%0d cleans=%0d required 0 0 0 0",
                     done_cnt, sweep_busy_o, al_nline.size(), clean_cnt);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        sweep_start_i = 1'b0;
        sweep_inval_i = 1'b0;
        flush_alloc_ready_i = 1'b1;
        flush_empty_i = 1'b1;
        reset_model();
        test_reset();
        test_no_dirty();
        test_dirty_pair();
        test_backpressure();
        test_gnt_delay();
        test_inval_restart();
        test_reset_in_scan();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
